// File: rtl/pipe_trace_unit_if.sv
// Trace bus between a pipeline model and the trace unit: fetch/stall/flush in, retire/kill/stats out.
// Latency: none, wiring only.
// Backpressure: none; the stall vector is the only hold mechanism and it is carried as plain data.
interface pipe_trace_unit_if #(
    parameter int NUM_STAGES = 5,
    parameter int DEPTH      = 8,
    parameter int PC_W       = 16,
    parameter int CYC_W      = 32
);
    localparam int TAG_W = $clog2(DEPTH);

    logic                  fetch_valid;
    logic [PC_W-1:0]       fetch_pc;
    logic [NUM_STAGES-1:0] stall;
    logic [NUM_STAGES-1:0] flush;

    logic                  retire_valid;
    logic [TAG_W-1:0]      retire_tag;
    logic [PC_W-1:0]       retire_pc;
    logic [CYC_W-1:0]      retire_fetch_cyc;
    logic [CYC_W-1:0]      retire_cyc;
    logic [7:0]            retire_stalls;
    logic                  kill_valid;
    logic [NUM_STAGES-1:0] kill_mask;
    logic [CYC_W-1:0]      cycle_count;
    logic [CYC_W-1:0]      retired_count;
    logic [CYC_W-1:0]      max_latency;

    // Pipeline side: drives fetch/stall/flush, observes trace results.
    modport master (
        output fetch_valid, fetch_pc, stall, flush,
        input  retire_valid, retire_tag, retire_pc, retire_fetch_cyc, retire_cyc,
        input  retire_stalls, kill_valid, kill_mask, cycle_count, retired_count, max_latency
    );

    // Trace unit side.
    modport slave (
        input  fetch_valid, fetch_pc, stall, flush,
        output retire_valid, retire_tag, retire_pc, retire_fetch_cyc, retire_cyc,
        output retire_stalls, kill_valid, kill_mask, cycle_count, retired_count, max_latency
    );
endinterface

// File: rtl/pipe_trace_unit.sv
// Shadows an in-order pipeline: tags each fetch, tracks it through the stages, reports retire/kill with cycle stamps.
// Latency: retire/kill outputs are registered, valid the cycle after the retiring/flushing edge.
// Backpressure: none upstream; stall back-propagates to freeze earlier stages, flush overrides everything.
module pipe_trace_unit #(
    parameter int NUM_STAGES = 5,
    parameter int DEPTH      = 8,
    parameter int PC_W       = 16,
    parameter int CYC_W      = 32
) (
    input  logic           clk,
    input  logic           rst,
    pipe_trace_unit_if.slave bus
);
    localparam int TAG_W = $clog2(DEPTH);

    // Stage occupancy and per-stage control
    logic [NUM_STAGES-1:0] hold;
    logic [NUM_STAGES-1:0] adv;
    logic [NUM_STAGES-1:0] stall_inc;
    logic [NUM_STAGES-1:0] stg_vld;
    logic [TAG_W-1:0]      stg_tag [NUM_STAGES];
    logic [TAG_W-1:0]      alloc_ptr;
    logic                  fetch_go;

    // Record table, indexed by tag
    logic [PC_W-1:0]       tbl_pc    [DEPTH];
    logic [CYC_W-1:0]      tbl_fcyc  [DEPTH];
    logic [7:0]            tbl_stalls[DEPTH];

    // Registered outputs and statistics
    logic [CYC_W-1:0]      cycle_q;
    logic [CYC_W-1:0]      retired_q;
    logic [CYC_W-1:0]      max_lat_q;
    logic                  ret_vld_q;
    logic [TAG_W-1:0]      ret_tag_q;
    logic [PC_W-1:0]       ret_pc_q;
    logic [CYC_W-1:0]      ret_fcyc_q;
    logic [CYC_W-1:0]      ret_cyc_q;
    logic [7:0]            ret_stalls_q;
    logic                  kill_vld_q;
    logic [NUM_STAGES-1:0] kill_mask_q;

    // Retiring record lookup
    logic [TAG_W-1:0]      out_tag;
    logic [CYC_W-1:0]      out_lat;
    logic                  ret_go;

    // A stage holds if it or any later stage stalls: OR of stall[k .. NUM_STAGES-1].
    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_hold
        assign hold[k] = |(bus.stall >> k);
    end

    // adv: the instruction leaves stage k at this edge (neither held nor killed).
    // A held or flushed stage sends a bubble downstream so nothing is duplicated or resurrected.
    assign adv       = stg_vld & ~hold & ~bus.flush;
    assign stall_inc = stg_vld & hold & ~bus.flush;
    assign fetch_go  = bus.fetch_valid & ~hold[0] & ~bus.flush[0];
    assign ret_go    = adv[NUM_STAGES-1];
    assign out_tag   = stg_tag[NUM_STAGES-1];
    assign out_lat   = cycle_q - tbl_fcyc[out_tag];

    // Free-running cycle stamp; value before the increment is the stamp of this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + CYC_W'(1);
        end
    end

    // Stage valid/tag shift with per-stage hold, flush taking priority over hold and incoming data.
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_vld   <= '0;
            alloc_ptr <= '0;
        end else begin
            if (bus.flush[0]) begin
                stg_vld[0] <= 1'b0;
            end else if (!hold[0]) begin
                stg_vld[0] <= bus.fetch_valid;
            end
            if (fetch_go) begin
                stg_tag[0] <= alloc_ptr;
                alloc_ptr  <= alloc_ptr + TAG_W'(1);
            end
            for (int k = 1; k < NUM_STAGES; k++) begin
                if (bus.flush[k]) begin
                    stg_vld[k] <= 1'b0;
                end else if (!hold[k]) begin
                    stg_vld[k] <= adv[k-1];
                    stg_tag[k] <= stg_tag[k-1];
                end
            end
        end
    end

    // Record table: capture on fetch, saturating stall counters for every held live stage.
    // Tags in flight are distinct (DEPTH > NUM_STAGES), so the per-stage writes never collide.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (stall_inc[k] && (tbl_stalls[stg_tag[k]] != 8'hFF)) begin
                tbl_stalls[stg_tag[k]] <= tbl_stalls[stg_tag[k]] + 8'd1;
            end
        end
        if (fetch_go) begin
            tbl_pc[alloc_ptr]     <= bus.fetch_pc;
            tbl_fcyc[alloc_ptr]   <= cycle_q;
            tbl_stalls[alloc_ptr] <= 8'd0;
        end
    end

    // Retire outputs: one-cycle pulse with the record of the instruction leaving the last stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            ret_vld_q    <= 1'b0;
            ret_tag_q    <= '0;
            ret_pc_q     <= '0;
            ret_fcyc_q   <= '0;
            ret_cyc_q    <= '0;
            ret_stalls_q <= '0;
        end else begin
            ret_vld_q <= ret_go;
            if (ret_go) begin
                ret_tag_q    <= out_tag;
                ret_pc_q     <= tbl_pc[out_tag];
                ret_fcyc_q   <= tbl_fcyc[out_tag];
                ret_cyc_q    <= cycle_q;
                ret_stalls_q <= tbl_stalls[out_tag];
            end
        end
    end

    // Retirement statistics: count and worst-case fetch-to-exit latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_q <= '0;
            max_lat_q <= '0;
        end else if (ret_go) begin
            retired_q <= retired_q + CYC_W'(1);
            if (out_lat > max_lat_q) begin
                max_lat_q <= out_lat;
            end
        end
    end

    // Kill report: which live stages were flushed at this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            kill_vld_q  <= 1'b0;
            kill_mask_q <= '0;
        end else begin
            kill_vld_q  <= |(bus.flush & stg_vld);
            kill_mask_q <= bus.flush & stg_vld;
        end
    end

    assign bus.retire_valid     = ret_vld_q;
    assign bus.retire_tag       = ret_tag_q;
    assign bus.retire_pc        = ret_pc_q;
    assign bus.retire_fetch_cyc = ret_fcyc_q;
    assign bus.retire_cyc       = ret_cyc_q;
    assign bus.retire_stalls    = ret_stalls_q;
    assign bus.kill_valid       = kill_vld_q;
    assign bus.kill_mask        = kill_mask_q;
    assign bus.cycle_count      = cycle_q;
    assign bus.retired_count    = retired_q;
    assign bus.max_latency      = max_lat_q;

endmodule

// File: tb/tb_pipe_trace_unit.sv
// Scoreboard bench for pipe_trace_unit: directed stimulus pushes expected retire/kill events,
// a negedge monitor pops and compares whenever the DUT pulses retire_valid or kill_valid.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_pipe_trace_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_trace_unit_if #(.NUM_STAGES(5), .DEPTH(8), .PC_W(16), .CYC_W(32)) bus ();

    pipe_trace_unit #(.NUM_STAGES(5), .DEPTH(8), .PC_W(16), .CYC_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [31:0] tag;
        logic [31:0] pc;
        logic [31:0] fc;
        logic [31:0] rc;
        logic [31:0] st;
    } ret_t;

    ret_t        rq[$];
    logic [4:0]  kq[$];
    int          total = 0;
    int          bad   = 0;
    ret_t        e;
    logic [4:0]  km;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push_ret(input logic [31:0] tag, input logic [31:0] pc, input logic [31:0] fc,
                            input logic [31:0] rc, input logic [31:0] st);
        ret_t r;
        r.tag = tag; r.pc = pc; r.fc = fc; r.rc = rc; r.st = st;
        rq.push_back(r);
    endtask

    // Present one cycle of inputs; the next rising edge consumes them.
    task automatic apply(input logic fv, input logic [15:0] pc, input logic [4:0] st, input logic [4:0] fl);
        bus.fetch_valid = fv;
        bus.fetch_pc    = pc;
        bus.stall       = st;
        bus.flush       = fl;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) apply(1'b0, 16'h0, 5'b0, 5'b0);
    endtask

    // One reset edge (optionally with fetch/flush active to show they are ignored), then check cleared outputs.
    task automatic do_reset(input logic fv, input logic [4:0] fl);
        rst = 1'b1;
        apply(fv, 16'h00FF, 5'b0, fl);
        chk("rst retire_valid", 32'(bus.retire_valid), 32'd0);
        chk("rst retire_tag", 32'(bus.retire_tag), 32'd0);
        chk("rst retire_pc", 32'(bus.retire_pc), 32'd0);
        chk("rst retire_fetch_cyc", bus.retire_fetch_cyc, 32'd0);
        chk("rst retire_cyc", bus.retire_cyc, 32'd0);
        chk("rst retire_stalls", 32'(bus.retire_stalls), 32'd0);
        chk("rst kill_valid", 32'(bus.kill_valid), 32'd0);
        chk("rst kill_mask", 32'(bus.kill_mask), 32'd0);
        chk("rst cycle_count", bus.cycle_count, 32'd0);
        chk("rst retired_count", bus.retired_count, 32'd0);
        chk("rst max_latency", bus.max_latency, 32'd0);
        rst = 1'b0;
        bus.fetch_valid = 1'b0;
        bus.flush       = '0;
    endtask

    task automatic end_test(input string nm, input logic [31:0] cnt, input logic [31:0] maxl);
        chk({nm, " retired_count"}, bus.retired_count, cnt);
        chk({nm, " max_latency"}, bus.max_latency, maxl);
        chk({nm, " missing retires"}, 32'(rq.size()), 32'd0);
        chk({nm, " missing kills"}, 32'(kq.size()), 32'd0);
        rq.delete();
        kq.delete();
    endtask

    // Monitor: every pulse must match the head of its queue; a pulse with nothing expected is a failure.
    always @(negedge clk) begin
        if (bus.retire_valid === 1'b1) begin
            if (rq.size() == 0) begin
                chk("unexpected retire pc", 32'(bus.retire_pc), 32'hFFFF_FFFF);
            end else begin
                e = rq.pop_front();
                chk("retire tag", 32'(bus.retire_tag), e.tag);
                chk("retire pc", 32'(bus.retire_pc), e.pc);
                chk("retire fetch_cyc", bus.retire_fetch_cyc, e.fc);
                chk("retire cyc", bus.retire_cyc, e.rc);
                chk("retire stalls", 32'(bus.retire_stalls), e.st);
            end
        end
        if (bus.kill_valid === 1'b1) begin
            if (kq.size() == 0) begin
                chk("unexpected kill mask", 32'(bus.kill_mask), 32'hFFFF_FFFF);
            end else begin
                km = kq.pop_front();
                chk("kill mask", 32'(bus.kill_mask), 32'(km));
            end
        end
    end

    initial begin
        bus.fetch_valid = 1'b0;
        bus.fetch_pc    = '0;
        bus.stall       = '0;
        bus.flush       = '0;
        rst             = 1'b1;

        // Single instruction, no hazards: fetch stamp 0, exit stamp 5.
        do_reset(1'b0, 5'b0);
        push_ret(0, 32'h10, 0, 5, 0);
        apply(1'b1, 16'h0010, 5'b0, 5'b0);
        chk("cycle_count after first edge", bus.cycle_count, 32'd1);
        idle(8);
        end_test("t1", 1, 5);

        // stall[2] for three edges while the instruction sits in stage 2.
        do_reset(1'b0, 5'b0);
        push_ret(0, 32'h22, 0, 8, 3);
        apply(1'b1, 16'h0022, 5'b0, 5'b0);
        idle(2);
        repeat (3) apply(1'b0, 16'h0, 5'b00100, 5'b0);
        idle(10);
        end_test("t2", 1, 8);

        // Flush beats stall in stage 1; later a flush including stage 0 blocks a fetch without using a tag.
        do_reset(1'b0, 5'b0);
        apply(1'b1, 16'h0030, 5'b0, 5'b0);
        idle(1);
        kq.push_back(5'b00010);
        apply(1'b0, 16'h0, 5'b00010, 5'b00010);
        apply(1'b1, 16'h0031, 5'b0, 5'b0);
        idle(1);
        kq.push_back(5'b00010);
        apply(1'b1, 16'h003F, 5'b0, 5'b10011);
        chk("t3 retired_count after kills", bus.retired_count, 32'd0);
        push_ret(2, 32'h32, 6, 11, 0);
        apply(1'b1, 16'h0032, 5'b0, 5'b0);
        idle(10);
        end_test("t3", 1, 5);

        // 20 back-to-back fetches, tags wrap modulo 8.
        do_reset(1'b0, 5'b0);
        for (int i = 0; i < 20; i++) begin
            push_ret(32'(i % 8), 32'(i), 32'(i), 32'(i + 5), 0);
            apply(1'b1, 16'(i), 5'b0, 5'b0);
        end
        idle(8);
        end_test("t4", 20, 5);

        // Long stall in the last stage: counter saturates at 255, latency 305.
        do_reset(1'b0, 5'b0);
        push_ret(0, 32'h55, 0, 305, 255);
        apply(1'b1, 16'h0055, 5'b0, 5'b0);
        idle(4);
        repeat (300) apply(1'b0, 16'h0, 5'b10000, 5'b0);
        idle(10);
        end_test("t5", 1, 305);

        // Fetch, retire and kill on the same edge.
        do_reset(1'b0, 5'b0);
        push_ret(0, 32'hA0, 0, 5, 0);
        push_ret(3, 32'hA4, 4, 9, 0);
        push_ret(4, 32'hA5, 5, 10, 0);
        apply(1'b1, 16'h00A0, 5'b0, 5'b0);
        apply(1'b1, 16'h00A1, 5'b0, 5'b0);
        apply(1'b1, 16'h00A2, 5'b0, 5'b0);
        idle(1);
        kq.push_back(5'b00010);
        apply(1'b1, 16'h00A4, 5'b0, 5'b00010);
        kq.push_back(5'b01000);
        apply(1'b1, 16'h00A5, 5'b0, 5'b01000);
        idle(10);
        end_test("t6", 3, 5);

        // Reset with four stages live (and flush/fetch asserted): nothing in flight may surface.
        do_reset(1'b0, 5'b0);
        apply(1'b1, 16'h0070, 5'b0, 5'b0);
        apply(1'b1, 16'h0071, 5'b0, 5'b0);
        apply(1'b1, 16'h0072, 5'b0, 5'b0);
        apply(1'b1, 16'h0073, 5'b0, 5'b0);
        do_reset(1'b1, 5'b11111);
        idle(12);
        end_test("t7", 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
